// File: rtl/pin_entry_if.sv
// Key-pulse / status bundle between the keyboard layer (master) and pin_entry_ctrl (slave).
interface pin_entry_if;
    logic       start_i;
    logic       abort_i;
    logic       digit_valid_i;
    logic [3:0] digit_i;
    logic       key_back_i;
    logic       key_correct_i;
    logic       key_enter_i;
    logic [2:0] digits_cnt_o;
    logic       entry_active_o;
    logic       pin_ok_o;
    logic       pin_fail_o;
    logic [2:0] tries_left_o;
    logic       locked_o;

    modport master (
        output start_i, abort_i, digit_valid_i, digit_i, key_back_i, key_correct_i, key_enter_i,
        input  digits_cnt_o, entry_active_o, pin_ok_o, pin_fail_o, tries_left_o, locked_o
    );

    modport slave (
        input  start_i, abort_i, digit_valid_i, digit_i, key_back_i, key_correct_i, key_enter_i,
        output digits_cnt_o, entry_active_o, pin_ok_o, pin_fail_o, tries_left_o, locked_o
    );
endinterface

// File: rtl/pin_entry_ctrl.sv
// PIN entry stage: collects BCD digits, supports back/correct edits, checks the entry
// against the stored PIN, counts failed attempts and enforces a timed lockout.
module pin_entry_ctrl #(
    parameter int unsigned          PIN_LEN     = 6,
    parameter logic [4*PIN_LEN-1:0] PIN_VALUE   = 24'h123456,
    parameter int unsigned          MAX_TRIES   = 3,
    parameter int unsigned          LOCK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    pin_entry_if.slave bus
);
    localparam int unsigned       LOCK_W      = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [2:0]        PIN_LEN_C   = 3'(PIN_LEN);
    localparam logic [2:0]        MAX_TRIES_C = 3'(MAX_TRIES);
    localparam logic [LOCK_W-1:0] LOCK_LAST   = LOCK_W'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENTRY,
        S_CHECK,
        S_LOCKED
    } state_e;

    state_e            state_q;
    logic [3:0]        buf_q [PIN_LEN];
    logic [2:0]        cnt_q;
    logic [2:0]        tries_q;
    logic [LOCK_W-1:0] lock_cnt_q;
    logic              entry_active_q;
    logic              pin_ok_q;
    logic              pin_fail_q;
    logic              locked_q;

    logic [4*PIN_LEN-1:0] entered;
    logic                 pin_match;
    logic                 digit_ok;

    // Pack the buffer first-entered-digit-most-significant so it lines up with PIN_VALUE.
    always_comb begin
        // NOTE: give every always_comb target a default first so no path can infer a latch.
        entered = '0;
        for (int i = 0; i < PIN_LEN; i++) begin
            entered[4*(PIN_LEN-1-i) +: 4] = buf_q[i];
        end
    end

    assign pin_match = (entered == PIN_VALUE);
    assign digit_ok  = bus.digit_valid_i && (bus.digit_i <= 4'd9) && (cnt_q < PIN_LEN_C);

    // Session FSM with all outputs registered alongside the state.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            // NOTE: the digit buffer is small and its reset value is defined, so it is reset like any flop.
            for (int i = 0; i < PIN_LEN; i++) buf_q[i] <= 4'd0;
            cnt_q          <= 3'd0;
            tries_q        <= MAX_TRIES_C;
            lock_cnt_q     <= '0;
            entry_active_q <= 1'b0;
            pin_ok_q       <= 1'b0;
            pin_fail_q     <= 1'b0;
            locked_q       <= 1'b0;
        end else begin
            pin_ok_q   <= 1'b0;
            pin_fail_q <= 1'b0;
            // The lock indicator follows the LOCKED state one cycle later, so it rises the
            // cycle after the final pin_fail pulse and stays up for LOCK_CYCLES cycles.
            locked_q   <= (state_q == S_LOCKED);

            unique case (state_q)
                S_IDLE: begin
                    if (bus.start_i) begin
                        state_q        <= S_ENTRY;
                        entry_active_q <= 1'b1;
                        cnt_q          <= 3'd0;
                        for (int i = 0; i < PIN_LEN; i++) buf_q[i] <= 4'd0;
                    end
                end

                S_ENTRY: begin
                    if (bus.abort_i) begin
                        state_q        <= S_IDLE;
                        entry_active_q <= 1'b0;
                        cnt_q          <= 3'd0;
                    end else if (bus.key_correct_i) begin
                        cnt_q <= 3'd0;
                    end else if (bus.key_back_i) begin
                        if (cnt_q != 3'd0) cnt_q <= cnt_q - 3'd1;
                    end else if (bus.key_enter_i) begin
                        // A short entry is ignored and does not cost an attempt.
                        if (cnt_q == PIN_LEN_C) begin
                            state_q        <= S_CHECK;
                            entry_active_q <= 1'b0;
                        end
                    end else if (digit_ok) begin
                        for (int i = 0; i < PIN_LEN; i++) begin
                            if (cnt_q == 3'(i)) buf_q[i] <= bus.digit_i;
                        end
                        cnt_q <= cnt_q + 3'd1;
                    end
                end

                S_CHECK: begin
                    cnt_q <= 3'd0;
                    if (bus.abort_i) begin
                        state_q <= S_IDLE;
                    end else if (pin_match) begin
                        pin_ok_q <= 1'b1;
                        tries_q  <= MAX_TRIES_C;
                        state_q  <= S_IDLE;
                    end else begin
                        pin_fail_q <= 1'b1;
                        tries_q    <= tries_q - 3'd1;
                        if (tries_q == 3'd1) begin
                            state_q    <= S_LOCKED;
                            lock_cnt_q <= '0;
                        end else begin
                            state_q        <= S_ENTRY;
                            entry_active_q <= 1'b1;
                        end
                    end
                end

                S_LOCKED: begin
                    if (lock_cnt_q == LOCK_LAST) begin
                        state_q    <= S_IDLE;
                        tries_q    <= MAX_TRIES_C;
                        lock_cnt_q <= '0;
                    end else begin
                        lock_cnt_q <= lock_cnt_q + 1'b1;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.digits_cnt_o   = cnt_q;
    assign bus.entry_active_o = entry_active_q;
    assign bus.pin_ok_o       = pin_ok_q;
    assign bus.pin_fail_o     = pin_fail_q;
    assign bus.tries_left_o   = tries_q;
    assign bus.locked_o       = locked_q;
endmodule

// File: tb/tb_pin_entry_ctrl.sv
// Self-checking bench for pin_entry_ctrl: directed scenarios followed by random key traffic,
// every cycle compared against a session-level reference model.
module tb_pin_entry_ctrl;
    localparam int PIN_LEN     = 6;
    localparam int PIN_DEC     = 123456;
    localparam int MAX_TRIES   = 3;
    localparam int LOCK_CYCLES = 20;

    logic clk;
    logic reset;
    pin_entry_if bus ();

    pin_entry_ctrl #(
        .PIN_LEN    (PIN_LEN),
        .PIN_VALUE  (24'h123456),
        .MAX_TRIES  (MAX_TRIES),
        .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: session phase name, queue of entered digits, attempts, lock time left.
    string m_phase;
    int    m_digits[$];
    int    m_tries;
    int    m_lock_left;
    int    e_ok, e_fail, e_locked;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase     = "IDLE";
        m_digits.delete();
        m_tries     = MAX_TRIES;
        m_lock_left = 0;
        e_ok        = 0;
        e_fail      = 0;
        e_locked    = 0;
    endtask

    task automatic model_step();
        int value;
        e_ok     = 0;
        e_fail   = 0;
        e_locked = (m_phase == "LOCKED");
        if (m_phase == "IDLE") begin
            if (bus.start_i) begin
                m_phase = "ENTRY";
                m_digits.delete();
            end
        end else if (m_phase == "ENTRY") begin
            if (bus.abort_i) begin
                m_phase = "IDLE";
                m_digits.delete();
            end else if (bus.key_correct_i) begin
                m_digits.delete();
            end else if (bus.key_back_i) begin
                if (m_digits.size() > 0) void'(m_digits.pop_back());
            end else if (bus.key_enter_i) begin
                if (m_digits.size() == PIN_LEN) m_phase = "CHECK";
            end else if (bus.digit_valid_i && bus.digit_i <= 9 && m_digits.size() < PIN_LEN) begin
                m_digits.push_back(int'(bus.digit_i));
            end
        end else if (m_phase == "CHECK") begin
            if (bus.abort_i) begin
                m_phase = "IDLE";
            end else begin
                value = 0;
                foreach (m_digits[i]) value = value * 10 + m_digits[i];
                if (value == PIN_DEC) begin
                    e_ok    = 1;
                    m_tries = MAX_TRIES;
                    m_phase = "IDLE";
                end else begin
                    e_fail  = 1;
                    m_tries = m_tries - 1;
                    if (m_tries == 0) begin
                        m_phase     = "LOCKED";
                        m_lock_left = LOCK_CYCLES;
                    end else begin
                        m_phase = "ENTRY";
                    end
                end
            end
            m_digits.delete();
        end else begin
            m_lock_left = m_lock_left - 1;
            if (m_lock_left == 0) begin
                m_phase = "IDLE";
                m_tries = MAX_TRIES;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_cnt"},    int'(bus.digits_cnt_o),   m_digits.size());
        chk({tag, "_active"}, int'(bus.entry_active_o), int'(m_phase == "ENTRY"));
        chk({tag, "_ok"},     int'(bus.pin_ok_o),       e_ok);
        chk({tag, "_fail"},   int'(bus.pin_fail_o),     e_fail);
        chk({tag, "_tries"},  int'(bus.tries_left_o),   m_tries);
        chk({tag, "_locked"}, int'(bus.locked_o),       e_locked);
    endtask

    task automatic clear_inputs();
        bus.start_i       = 1'b0;
        bus.abort_i       = 1'b0;
        bus.digit_valid_i = 1'b0;
        bus.digit_i       = 4'd0;
        bus.key_back_i    = 1'b0;
        bus.key_correct_i = 1'b0;
        bus.key_enter_i   = 1'b0;
    endtask

    // One clock: model follows the edge, outputs checked 1 time unit later, inputs released.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all("cyc");
        clear_inputs();
    endtask

    task automatic do_start();       bus.start_i = 1'b1;       tick(); endtask
    task automatic do_back();        bus.key_back_i = 1'b1;    tick(); endtask
    task automatic do_correct();     bus.key_correct_i = 1'b1; tick(); endtask
    task automatic do_enter();       bus.key_enter_i = 1'b1;   tick(); endtask
    task automatic do_abort();       bus.abort_i = 1'b1;       tick(); endtask
    task automatic do_digit(input logic [3:0] d);
        bus.digit_valid_i = 1'b1;
        bus.digit_i       = d;
        tick();
    endtask
    task automatic do_pin(input logic [23:0] bcd);
        for (int i = 0; i < 6; i++) do_digit(bcd[4*(5-i) +: 4]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lock_seen;
        int guard;
        logic [3:0] seq [8];

        clear_inputs();
        model_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all("rst");
        chk("rst_tries_const", int'(bus.tries_left_o), 3);
        @(negedge clk);
        reset = 1'b1;

        // Correct entry: pin_ok exactly two cycles after enter.
        do_start();
        do_pin(24'h123456);
        do_enter();
        chk("t1_ok_n1", int'(bus.pin_ok_o), 0);
        tick();
        chk("t1_ok_n2", int'(bus.pin_ok_o), 1);
        chk("t1_cnt", int'(bus.digits_cnt_o), 0);
        tick();
        chk("t1_ok_n3", int'(bus.pin_ok_o), 0);
        chk("t1_tries", int'(bus.tries_left_o), 3);
        chk("t1_active", int'(bus.entry_active_o), 0);

        // Editing: digits_cnt follows 1,2,3,2,3,4,5,6 and the edited PIN matches.
        seq = '{4'd1, 4'd2, 4'd9, 4'hF, 4'd3, 4'd4, 4'd5, 4'd6};
        do_start();
        for (int i = 0; i < 8; i++) begin
            if (seq[i] == 4'hF) do_back(); else do_digit(seq[i]);
        end
        chk("t2_cnt_final", int'(bus.digits_cnt_o), 6);
        do_enter();
        tick();
        chk("t2_ok", int'(bus.pin_ok_o), 1);
        do_start();
        do_pin(24'h987654);
        do_back(); do_back();
        do_correct();
        chk("t2_correct", int'(bus.digits_cnt_o), 0);

        // Boundaries.
        do_pin(24'h111111);
        do_digit(4'd7);
        chk("t4_7th_dropped", int'(bus.digits_cnt_o), 6);
        do_back();
        do_enter();
        tick();
        chk("t4_short_enter_active", int'(bus.entry_active_o), 1);
        chk("t4_short_enter_tries", int'(bus.tries_left_o), 3);
        do_correct();
        do_back();
        chk("t4_back_at_0", int'(bus.digits_cnt_o), 0);
        do_digit(4'hA);
        chk("t4_digit_A", int'(bus.digits_cnt_o), 0);
        do_digit(4'd1); do_digit(4'd2);
        bus.digit_valid_i = 1'b1;
        bus.digit_i       = 4'd3;
        do_back();
        chk("t4_digit_and_back", int'(bus.digits_cnt_o), 1);

        // Abort at three digits.
        do_digit(4'd2); do_digit(4'd3);
        do_abort();
        chk("t5_abort_cnt", int'(bus.digits_cnt_o), 0);
        chk("t5_abort_active", int'(bus.entry_active_o), 0);
        tick();
        chk("t5_abort_no_pulse", int'(bus.pin_ok_o | bus.pin_fail_o), 0);

        // Lockout after three mismatches; start ignored while locked.
        do_start();
        for (int k = 1; k <= 3; k++) begin
            do_pin(24'h000000);
            do_enter();
            tick();
            chk("t3_fail", int'(bus.pin_fail_o), 1);
            chk("t3_tries", int'(bus.tries_left_o), 3 - k);
        end
        chk("t3_locked_not_yet", int'(bus.locked_o), 0);
        lock_seen = 0;
        guard     = 0;
        do begin
            if (m_phase == "LOCKED") bus.start_i = 1'b1;
            tick();
            if (bus.locked_o) lock_seen++;
            guard++;
        end while ((bus.locked_o || lock_seen == 0) && guard < 3 * LOCK_CYCLES);
        chk("t3_lock_len", lock_seen, LOCK_CYCLES);
        chk("t3_tries_release", int'(bus.tries_left_o), 3);
        chk("t3_start_ignored", int'(bus.entry_active_o), 0);

        // Reset in the middle of a lockout.
        do_start();
        for (int k = 1; k <= 3; k++) begin
            do_pin(24'h654321);
            do_enter();
            tick();
        end
        repeat (4) tick();
        chk("t5_locked_before_rst", int'(bus.locked_o), 1);
        reset = 1'b0;
        #2;
        chk("t5_rst_locked", int'(bus.locked_o), 0);
        chk("t5_rst_tries", int'(bus.tries_left_o), 3);
        model_reset();
        check_all("t5_rst");
        #2;
        reset = 1'b1;

        // Random key traffic, biased towards the correct next digit.
        for (int c = 0; c < 3000; c++) begin
            bus.start_i       = ($urandom_range(7) == 0);
            bus.abort_i       = ($urandom_range(59) == 0);
            bus.key_correct_i = ($urandom_range(49) == 0);
            bus.key_back_i    = ($urandom_range(19) == 0);
            bus.key_enter_i   = ($urandom_range(5) == 0);
            bus.digit_valid_i = ($urandom_range(1) == 0);
            if ($urandom_range(3) != 0) bus.digit_i = 4'(m_digits.size() + 1);
            else                        bus.digit_i = 4'($urandom_range(15));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
